// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by hazard_controller and forwarding_unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'b00,
        HZ_MISS   = 2'b01,
        HZ_RESUME = 2'b10
    } hz_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // The Memory-stage ALU result is younger than the Writeback result, so it wins.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       reg_write_m,
        input logic [4:0] rd_w,
        input logic       reg_write_w
    );
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/hazard_forwarding_unit.sv
// Purely combinational operand-forwarding select for the two EX operand muxes.
// Register x0 is never forwarded because it is hard-wired to zero.
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output fwd_sel_t   ForwardAE,
    output fwd_sel_t   ForwardBE
);

    always_comb begin
        ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: stall/flush control, EX forwarding selects and a data-cache miss FSM.
// Optional HAZARD_PERF_EN adds StallCycles/FlushCount performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MISS_TIMEOUT = 1024
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic [1:0] ResultSrcE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       PCSrcE,
    input  logic       MemAccessM,
    input  logic       CacheHitM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       StallW,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MissTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] StallCycles,
    output logic [CNT_WIDTH-1:0] FlushCount
`endif
);

    localparam int CW = $clog2(MISS_TIMEOUT);
    localparam logic [CW-1:0] COUNT_MAX = CW'(MISS_TIMEOUT - 1);

    hz_state_t      state;
    hz_state_t      state_next;
    logic [CW-1:0]  miss_count;
    logic           miss_seen;
    logic           lw_stall;
    logic           freeze;
    logic           resolve;
    fwd_sel_t       fwd_a;
    fwd_sel_t       fwd_b;

    forwarding_unit u_forwarding_unit (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    assign ForwardAE = rst ? FWD_RF : fwd_a;
    assign ForwardBE = rst ? FWD_RF : fwd_b;

    assign miss_seen = MemAccessM && !CacheHitM;
    assign lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HZ_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            HZ_RUN:    if (miss_seen) state_next = HZ_MISS;
            HZ_MISS:   if (MemReadyM) state_next = HZ_RESUME;
            HZ_RESUME: state_next = HZ_RUN;
            default:   state_next = HZ_RUN;
        endcase
    end

    // The count saturates so a very long fill cannot wrap and hide the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count  <= '0;
            MissTimeout <= 1'b0;
        end else if ((state == HZ_RUN) && miss_seen) begin
            miss_count <= '0;
        end else if (state == HZ_MISS) begin
            if (miss_count != COUNT_MAX) begin
                miss_count <= miss_count + 1'b1;
            end
            if ((int'(miss_count) + 1) >= (MISS_TIMEOUT - 1)) begin
                MissTimeout <= 1'b1;
            end
        end
    end

    always_comb begin
        freeze  = 1'b0;
        resolve = 1'b0;
        unique case (state)
            HZ_RUN: begin
                if (miss_seen) freeze = 1'b1;
                else           resolve = 1'b1;
            end
            HZ_MISS:   freeze  = 1'b1;
            HZ_RESUME: resolve = 1'b1;
            default:   resolve = 1'b1;
        endcase
    end

    // A taken branch makes the load-use stall moot: both younger instructions are wrong-path.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        StallW = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            StallW = 1'b1;
        end else if (resolve) begin
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (StallF) StallCycles <= StallCycles + CNT_WIDTH'(1);
            if (FlushE) FlushCount  <= FlushCount + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by random stimulus,
// all compared against a cycle-level reference model of the sequencing rules.
module tb_hazard_controller;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       RegWriteM, RegWriteW, PCSrcE, MemAccessM, CacheHitM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MissTimeout;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: whether the pipe is frozen on a fill, whether the one-cycle
    // post-fill window is active, how many frozen cycles have elapsed, and the sticky flag.
    bit in_miss;
    bit in_resume;
    int miss_n;
    bit timeout_m;

    always #5 clk = ~clk;

    hazard_controller #(.MISS_TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .ResultSrcE  (ResultSrcE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .PCSrcE      (PCSrcE),
        .MemAccessM  (MemAccessM),
        .CacheHitM   (CacheHitM),
        .MemReadyM   (MemReadyM),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .StallM      (StallM),
        .StallW      (StallW),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .MissTimeout (MissTimeout)
`ifdef HAZARD_PERF_EN
        ,
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_idle();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {RegWriteM, RegWriteW, PCSrcE, MemAccessM, CacheHitM, MemReadyM} = '0;
    endtask

    // Compare every output against the model, just after the inputs have settled.
    task automatic settle_and_check();
        logic [1:0] e_fa, e_fb;
        logic e_sf, e_sd, e_sx, e_fd, e_fe;
        bit lw, frozen;
        if (rst) begin
            in_miss = 0;
            in_resume = 0;
            miss_n = 0;
            timeout_m = 0;
        end
        #1;
        e_fa = rst ? 2'b00 : ref_fwd(Rs1E);
        e_fb = rst ? 2'b00 : ref_fwd(Rs2E);
        {e_sf, e_sd, e_sx, e_fd, e_fe} = '0;
        lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        frozen = in_miss || (!in_resume && MemAccessM && !CacheHitM);
        if (rst) begin
            e_fd = 1; e_fe = 1;
        end else if (frozen) begin
            e_sf = 1; e_sd = 1; e_sx = 1;
        end else if (PCSrcE) begin
            e_fd = 1; e_fe = 1;
        end else if (lw) begin
            e_sf = 1; e_sd = 1; e_fe = 1;
        end
        check_output("StallF", StallF, e_sf);
        check_output("StallD", StallD, e_sd);
        check_output("StallE", StallE, e_sx);
        check_output("StallM", StallM, e_sx);
        check_output("StallW", StallW, e_sx);
        check_output("FlushD", FlushD, e_fd);
        check_output("FlushE", FlushE, e_fe);
        check_output("ForwardAE", ForwardAE, e_fa);
        check_output("ForwardBE", ForwardBE, e_fb);
        check_output("MissTimeout", MissTimeout, timeout_m);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            if (in_miss) begin
                if (miss_n + 1 >= TIMEOUT) timeout_m = 1;
                if (MemReadyM) begin
                    in_miss = 0;
                    in_resume = 1;
                end else begin
                    miss_n++;
                end
            end else if (in_resume) begin
                in_resume = 0;
            end else if (MemAccessM && !CacheHitM) begin
                in_miss = 1;
                miss_n = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_stimulus();
        settle_and_check();
        advance();
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        settle_and_check();
        check_output("reset_flushE", FlushE, 1);
        check_output("reset_stallF", StallF, 0);
        advance();
        rst = 1'b0;
        apply_stimulus();

        // Forwarding priority
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        settle_and_check();
        check_output("fwd_mem", ForwardAE, 2'b10);
        advance();
        RdM = 0;
        settle_and_check();
        check_output("fwd_wb", ForwardAE, 2'b01);
        advance();
        Rs1E = 0;
        settle_and_check();
        check_output("fwd_x0", ForwardAE, 2'b00);
        advance();
        set_idle();

        // Load-use, then load-use shadowed by a taken branch
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        settle_and_check();
        check_output("lw_stallD", StallD, 1);
        check_output("lw_flushD", FlushD, 0);
        advance();
        PCSrcE = 1;
        settle_and_check();
        check_output("br_flushD", FlushD, 1);
        check_output("br_stallF", StallF, 0);
        advance();
        set_idle();

        // Miss with a branch held in EX: flush deferred to RESUME
        MemAccessM = 1; PCSrcE = 1;
        settle_and_check();
        check_output("missbr_run_flushE", FlushE, 0);
        advance();
        apply_stimulus();
        MemReadyM = 1;
        apply_stimulus();
        MemReadyM = 0;
        settle_and_check();
        check_output("missbr_resume_flushD", FlushD, 1);
        check_output("missbr_resume_stallF", StallF, 0);
        advance();
        set_idle();
        apply_stimulus();

        // Ten-cycle fill; CacheHitM stays low through RESUME and must be ignored there
        MemAccessM = 1;
        settle_and_check();
        check_output("miss_first_stallW", StallW, 1);
        advance();
        for (int i = 1; i < 10; i++) apply_stimulus();
        MemReadyM = 1;
        settle_and_check();
        check_output("miss_ready_stallF", StallF, 1);
        advance();
        MemReadyM = 0;
        settle_and_check();
        check_output("resume_stallF", StallF, 0);
        advance();
        set_idle();
        apply_stimulus();

        // Timeout, then reset in the middle of the fill
        rst = 1;
        apply_stimulus();
        rst = 0;
        MemAccessM = 1;
        apply_stimulus();
        for (int n = 1; n <= 7; n++) begin
            settle_and_check();
            if (n == 7) check_output("timeout_not_yet", MissTimeout, 0);
            advance();
        end
        settle_and_check();
        check_output("timeout_8th", MissTimeout, 1);
        check_output("timeout_stallM", StallM, 1);
        advance();
        rst = 1;
        settle_and_check();
        check_output("rstmiss_timeout", MissTimeout, 0);
        check_output("rstmiss_flushE", FlushE, 1);
        advance();
        rst = 0;
        set_idle();
        settle_and_check();
        check_output("rstmiss_run_stallF", StallF, 0);
        advance();

`ifdef HAZARD_PERF_EN
        rst = 1;
        apply_stimulus();
        rst = 0;
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        for (int i = 0; i < 3; i++) apply_stimulus();
        set_idle();
        PCSrcE = 1;
        apply_stimulus();
        PCSrcE = 0;
        settle_and_check();
        check_output("perf_stall_cycles", StallCycles, 3);
        check_output("perf_flush_count", FlushCount, 4);
        advance();
`endif

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            Rs1D = 5'($urandom_range(0, 7));
            Rs2D = 5'($urandom_range(0, 7));
            Rs1E = 5'($urandom_range(0, 7));
            Rs2E = 5'($urandom_range(0, 7));
            RdE  = 5'($urandom_range(0, 7));
            RdM  = 5'($urandom_range(0, 7));
            RdW  = 5'($urandom_range(0, 7));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 5) == 0);
            MemAccessM = ($urandom_range(0, 3) == 0);
            CacheHitM  = ($urandom_range(0, 3) != 0);
            MemReadyM  = ($urandom_range(0, 9) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            apply_stimulus();
        end
        rst = 0;
        set_idle();
        apply_stimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
